// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single Data_Memory block-transfer port between two cache
//   requesters (port 0 = instruction cache, port 1 = dcache_top). One port is
//   granted at a time. Ties are broken round-robin, or always in favour of
//   port 1 when FIXED_PRI = 1. A grant is held until memory acks. A watchdog
//   aborts a grant that is never acked.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   reqN_enable_i/write_i/addr_i/data_i   requester N line request
//   ackN_o, rdataN_o              requester N completion pulse and read data
//   mem_enable_o/write_o/addr_o/data_o    towards Data_Memory
//   mem_ack_i, mem_data_i         from Data_Memory
//   busy_o                        a grant is active
//   timeout_o                     1-cycle pulse when the watchdog aborts a grant
//
// state | meaning
// IDLE  | no grant; memory enable low; arbitration happens here
// GNT0  | port 0 owns the memory port
// GNT1  | port 1 owns the memory port

module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int TIMEOUT   = 64,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              ack0_o,
  output logic [DATA_W-1:0] rdata0_o,
  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic              timeout_o
);

  // With TIMEOUT = 0 the counter is kept one bit wide and simply saturates.
  localparam int             CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit             WD_EN   = (TIMEOUT > 0);
  localparam bit             RR_EN   = (FIXED_PRI == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last;
  logic [CNT_W-1:0] r_wait_cnt;

  logic w_gnt0;
  logic w_gnt1;
  logic w_tmo;

  assign w_gnt0 = (r_state == GNT0);
  assign w_gnt1 = (r_state == GNT1);

  // Reset wins over a same-cycle ack or timeout: the grant is simply dropped.
  // An ack landing on the terminal count also wins over the timeout.
  assign w_tmo = WD_EN && (w_gnt0 || w_gnt1) && !mem_ack_i && !rst_i &&
                 (r_wait_cnt == CNT_TC);

  assign busy_o       = w_gnt0 || w_gnt1;
  assign mem_enable_o = w_gnt0 || w_gnt1;
  assign mem_write_o  = (w_gnt0 && req0_write_i) || (w_gnt1 && req1_write_i);
  assign mem_addr_o   = w_gnt0 ? req0_addr_i : (w_gnt1 ? req1_addr_i : '0);
  assign mem_data_o   = w_gnt0 ? req0_data_i : (w_gnt1 ? req1_data_i : '0);

  // An ack seen in IDLE is stale and goes nowhere.
  assign ack0_o    = w_gnt0 && mem_ack_i && !rst_i;
  assign ack1_o    = w_gnt1 && mem_ack_i && !rst_i;
  assign rdata0_o  = ack0_o ? mem_data_i : '0;
  assign rdata1_o  = ack1_o ? mem_data_i : '0;
  assign timeout_o = w_tmo;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_wait_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // Counter held at zero here so every grant starts from 0.
          r_wait_cnt <= '0;
          if (req0_enable_i && (!req1_enable_i || (RR_EN && r_last))) begin
            r_state <= GNT0;
          end else if (req1_enable_i) begin
            r_state <= GNT1;
          end
        end
        GNT0, GNT1: begin
          if (mem_ack_i || w_tmo) begin
            r_state <= IDLE;
            r_last  <= w_gnt1;
          end else if (r_wait_cnt != CNT_MAX) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Instance A uses the default TIMEOUT
//   (64); instance B shares the same inputs with TIMEOUT = 8 for the watchdog
//   cases. Inputs change on the falling edge, outputs are sampled there too.

module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_en, req0_wr, req1_en, req1_wr;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              a_ack0, a_ack1, a_mem_en, a_mem_wr, a_busy, a_tmo;
  logic [DATA_W-1:0] a_rdata0, a_rdata1, a_mem_data;
  logic [ADDR_W-1:0] a_mem_addr;
  logic              b_ack0, b_ack1, b_mem_en, b_mem_wr, b_busy, b_tmo;
  logic [DATA_W-1:0] b_rdata0, b_rdata1, b_mem_data;
  logic [ADDR_W-1:0] b_mem_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(64), .FIXED_PRI(0)) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .req0_enable_i(req0_en), .req0_write_i(req0_wr), .req0_addr_i(req0_addr), .req0_data_i(req0_data),
    .ack0_o(a_ack0), .rdata0_o(a_rdata0),
    .req1_enable_i(req1_en), .req1_write_i(req1_wr), .req1_addr_i(req1_addr), .req1_data_i(req1_data),
    .ack1_o(a_ack1), .rdata1_o(a_rdata1),
    .mem_enable_o(a_mem_en), .mem_write_o(a_mem_wr), .mem_addr_o(a_mem_addr), .mem_data_o(a_mem_data),
    .mem_ack_i(mem_ack), .mem_data_i(mem_rdata),
    .busy_o(a_busy), .timeout_o(a_tmo)
  );

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8), .FIXED_PRI(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .req0_enable_i(req0_en), .req0_write_i(req0_wr), .req0_addr_i(req0_addr), .req0_data_i(req0_data),
    .ack0_o(b_ack0), .rdata0_o(b_rdata0),
    .req1_enable_i(req1_en), .req1_write_i(req1_wr), .req1_addr_i(req1_addr), .req1_data_i(req1_data),
    .ack1_o(b_ack1), .rdata1_o(b_rdata1),
    .mem_enable_o(b_mem_en), .mem_write_o(b_mem_wr), .mem_addr_o(b_mem_addr), .mem_data_o(b_mem_data),
    .mem_ack_i(mem_ack), .mem_data_i(mem_rdata),
    .busy_o(b_busy), .timeout_o(b_tmo)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Call on a falling edge of an IDLE cycle with the request already raised.
  // Checks the grant on instance A for dly+1 cycles, acks in the last one and
  // returns on the falling edge of the following IDLE cycle.
  task automatic serve(input string tag, input int port, input logic [31:0] exp_addr,
                       input logic exp_wr, input logic [255:0] exp_wdata,
                       input int dly, input logic [255:0] rd);
    @(negedge clk);
    check({tag, "_en"}, 256'(a_mem_en), 256'(1));
    check({tag, "_busy"}, 256'(a_busy), 256'(1));
    for (int i = 0; i <= dly; i++) begin
      check({tag, "_addr"}, 256'(a_mem_addr), 256'(exp_addr));
      check({tag, "_wr"}, 256'(a_mem_wr), 256'(exp_wr));
      check({tag, "_wdata"}, a_mem_data, exp_wdata);
      if (i < dly) begin
        check({tag, "_ack_early"}, 256'({a_ack1, a_ack0}), 256'(0));
        @(negedge clk);
      end
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    #1;
    check({tag, "_ack0"}, 256'(a_ack0), 256'(port == 0));
    check({tag, "_ack1"}, 256'(a_ack1), 256'(port == 1));
    check({tag, "_rdata0"}, a_rdata0, (port == 0) ? rd : 256'(0));
    check({tag, "_rdata1"}, a_rdata1, (port == 1) ? rd : 256'(0));
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check({tag, "_idle"}, 256'(a_busy), 256'(0));
    check({tag, "_idle_en"}, 256'(a_mem_en), 256'(0));
    check({tag, "_ack_once"}, 256'({a_ack1, a_ack0}), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [255:0] pat_a5;
    logic [255:0] pat_rd;
    pat_a5 = {32{8'hA5}};
    pat_rd = {8{32'hDEAD_BEEF}};

    rst = 1'b1;
    req0_en = 0; req0_wr = 0; req0_addr = '0; req0_data = '0;
    req1_en = 0; req1_wr = 0; req1_addr = '0; req1_data = '0;
    mem_ack = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_busy", 256'(a_busy), 256'(0));
    check("rst_en", 256'(a_mem_en), 256'(0));
    check("rst_wr", 256'(a_mem_wr), 256'(0));
    check("rst_addr", 256'(a_mem_addr), 256'(0));
    check("rst_acks", 256'({a_ack1, a_ack0, a_tmo}), 256'(0));
    check("rst_b_busy", 256'(b_busy), 256'(0));

    // 1: solo read on port 0, ack on the 10th grant cycle
    req0_en = 1; req0_addr = 32'h40; req0_data = {8{32'h1111_0000}};
    serve("t1", 0, 32'h40, 1'b0, req0_data, 9, pat_rd);
    req0_en = 0;

    // 2: tie after reset -> 0, then 1, then 0 again
    do_reset();
    req0_en = 1; req0_addr = 32'h40;
    req1_en = 1; req1_addr = 32'h100; req1_data = {8{32'h2222_0000}};
    serve("t2_g0", 0, 32'h40, 1'b0, req0_data, 0, {8{32'h0000_0A0A}});
    req0_en = 0;
    serve("t2_g1", 1, 32'h100, 1'b0, req1_data, 1, {8{32'h0000_0B0B}});
    req0_en = 1;
    serve("t2_rep_g0", 0, 32'h40, 1'b0, req0_data, 0, {8{32'h0000_0C0C}});

    // 3: both held high -> strict alternation 1,0,1,0
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        serve("t3_g1", 1, 32'h100, 1'b0, req1_data, 2, 256'(k + 1));
      else
        serve("t3_g0", 0, 32'h40, 1'b0, req0_data, 2, 256'(k + 1));
    end
    req0_en = 0; req1_en = 0;

    // 4: write path on port 1
    req1_en = 1; req1_wr = 1; req1_addr = 32'h80; req1_data = pat_a5;
    serve("t4", 1, 32'h80, 1'b1, pat_a5, 3, {8{32'h3333_3333}});
    req1_en = 0; req1_wr = 0;

    // 5: watchdog on instance B (TIMEOUT = 8)
    do_reset();
    req0_en = 1; req0_addr = 32'h40;
    req1_addr = 32'h100;
    @(negedge clk);
    req1_en = 1;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      check("t5_tmo", 256'(b_tmo), 256'(k == 8));
      check("t5_no_ack", 256'({b_ack1, b_ack0}), 256'(0));
      check("t5_busy", 256'(b_busy), 256'(1));
    end
    @(negedge clk);
    check("t5_idle", 256'(b_busy), 256'(0));
    check("t5_tmo_once", 256'(b_tmo), 256'(0));
    @(negedge clk);
    check("t5_next_gnt", 256'(b_mem_addr), 256'(32'h100));
    check("t5_next_en", 256'(b_mem_en), 256'(1));
    // ack on the terminal-count cycle: ack wins over timeout
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) check("t5b_tmo_early", 256'(b_tmo), 256'(0));
    end
    mem_ack = 1; mem_rdata = pat_rd;
    #1;
    check("t5b_ack1", 256'(b_ack1), 256'(1));
    check("t5b_tmo_masked", 256'(b_tmo), 256'(0));
    check("t5b_rdata1", b_rdata1, pat_rd);
    @(negedge clk);
    mem_ack = 0; mem_rdata = '0;
    req0_en = 0; req1_en = 0;
    check("t5b_idle", 256'(b_busy), 256'(0));

    // 6: reset during GNT1, then a stale ack in IDLE
    do_reset();
    req1_en = 1; req1_addr = 32'h80; req1_wr = 0;
    @(negedge clk);
    check("t6_gnt1", 256'(a_mem_addr), 256'(32'h80));
    check("t6_busy", 256'(a_busy), 256'(1));
    rst = 1; req1_en = 0;
    @(negedge clk);
    rst = 0;
    check("t6_en", 256'(a_mem_en), 256'(0));
    check("t6_busy_rst", 256'(a_busy), 256'(0));
    check("t6_addr", 256'(a_mem_addr), 256'(0));
    check("t6_tmo", 256'(a_tmo), 256'(0));
    mem_ack = 1; mem_rdata = pat_rd;
    #1;
    check("t6_stale_acks", 256'({a_ack1, a_ack0}), 256'(0));
    check("t6_stale_rd0", a_rdata0, 256'(0));
    check("t6_stale_rd1", a_rdata1, 256'(0));
    @(negedge clk);
    mem_ack = 0; mem_rdata = '0;
    check("t6_still_idle", 256'(a_busy), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
